// File: rtl/cpu_accel_port.sv
// Buffered CPU <-> accelerator port: two FWFT FIFOs plus sticky overflow/underflow flags.
// Latency: a word pushed in cycle N is visible at the far side in cycle N+1; one word/cycle per direction.
// Backpressure: full/empty decided from start-of-cycle count; CPU writes to a full FIFO and reads of an empty one are dropped and flagged.

// Generic FWFT FIFO used for both directions.
// Latency: push in cycle N shows up at the head in N+1; head is a combinational read of mem[rd_ptr].
// Backpressure: push is ignored when the count is DEPTH, pop when it is 0, both judged at cycle start.
module cpu_accel_port_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_push_vld,
   input  logic [DATA_WIDTH-1:0] i_push_dat,
   input  logic                  i_pop_rdy,
   output logic                  o_not_full,
   output logic                  o_not_empty,
   output logic [DATA_WIDTH-1:0] o_head_dat
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  w_push;
   logic                  w_pop;

   // A full FIFO rejects the push even when a pop frees a slot this cycle.
   assign w_push      = i_push_vld && (r_count != FULL_CNT);
   assign w_pop       = i_pop_rdy && (r_count != '0);
   assign o_not_full  = (r_count != FULL_CNT);
   assign o_not_empty = (r_count != '0);
   assign o_head_dat  = r_mem[r_rd_ptr];

   // Storage write; contents survive reset, only the pointers are cleared.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   // Pointer and occupancy bookkeeping; reset discards all buffered words.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// CPU <-> accelerator port top: to-accel and from-accel FIFOs with CPU-side status for jump conditions.
// Latency: CPU write visible as accel_in_valid next cycle; accelerator result visible as can_read next cycle.
// Backpressure: accelerator side is valid/ready; CPU side strobes are dropped and flagged when they cannot proceed.
module cpu_accel_port #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_cpu_write_en,
   input  logic [DATA_WIDTH-1:0] i_cpu_write_data,
   input  logic                  i_cpu_read_en,
   output logic [DATA_WIDTH-1:0] o_cpu_read_data,
   output logic                  o_accel_can_write,
   output logic                  o_accel_can_read,
   output logic                  o_overflow,
   output logic                  o_underflow,
   output logic                  o_accel_in_valid,
   output logic [DATA_WIDTH-1:0] o_accel_in_data,
   input  logic                  i_accel_in_ready,
   input  logic                  i_accel_out_valid,
   input  logic [DATA_WIDTH-1:0] i_accel_out_data,
   output logic                  o_accel_out_ready
);
   logic w_to_not_full;
   logic w_to_not_empty;
   logic w_from_not_full;
   logic w_from_not_empty;
   logic r_overflow;
   logic r_underflow;

   cpu_accel_port_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_to_accel (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push_vld  (i_cpu_write_en),
      .i_push_dat  (i_cpu_write_data),
      .i_pop_rdy   (i_accel_in_ready),
      .o_not_full  (w_to_not_full),
      .o_not_empty (w_to_not_empty),
      .o_head_dat  (o_accel_in_data)
   );

   cpu_accel_port_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_from_accel (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push_vld  (i_accel_out_valid),
      .i_push_dat  (i_accel_out_data),
      .i_pop_rdy   (i_cpu_read_en),
      .o_not_full  (w_from_not_full),
      .o_not_empty (w_from_not_empty),
      .o_head_dat  (o_cpu_read_data)
   );

   // Status comes straight from registered counts, never from this cycle's inputs.
   assign o_accel_can_write = w_to_not_full;
   assign o_accel_in_valid  = w_to_not_empty;
   assign o_accel_can_read  = w_from_not_empty;
   assign o_accel_out_ready = w_from_not_full;
   assign o_overflow        = r_overflow;
   assign o_underflow       = r_underflow;

   // Sticky error flags for dropped CPU accesses; only reset clears them.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (i_cpu_write_en && !w_to_not_full) begin
            r_overflow <= 1'b1;
         end
         if (i_cpu_read_en && !w_from_not_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cpu_accel_port.sv
module tb_cpu_accel_port;
   localparam int DW = 32;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_write_en = 1'b0;
   logic [DW-1:0] cpu_write_data = '0;
   logic          cpu_read_en = 1'b0;
   logic [DW-1:0] cpu_read_data;
   logic          accel_can_write, accel_can_read, overflow, underflow;
   logic          accel_in_valid;
   logic [DW-1:0] accel_in_data;
   logic          accel_in_ready = 1'b0;
   logic          accel_out_valid = 1'b0;
   logic [DW-1:0] accel_out_data = '0;
   logic          accel_out_ready;

   cpu_accel_port #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_cpu_write_en    (cpu_write_en),
      .i_cpu_write_data  (cpu_write_data),
      .i_cpu_read_en     (cpu_read_en),
      .o_cpu_read_data   (cpu_read_data),
      .o_accel_can_write (accel_can_write),
      .o_accel_can_read  (accel_can_read),
      .o_overflow        (overflow),
      .o_underflow       (underflow),
      .o_accel_in_valid  (accel_in_valid),
      .o_accel_in_data   (accel_in_data),
      .i_accel_in_ready  (accel_in_ready),
      .i_accel_out_valid (accel_out_valid),
      .i_accel_out_data  (accel_out_data),
      .o_accel_out_ready (accel_out_ready)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: plain queues and flags.
   logic [DW-1:0] m_to[$];
   logic [DW-1:0] m_from[$];
   bit            m_ov = 0;
   bit            m_un = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit to_push, to_pop, fr_push, fr_pop;
      if (rst) begin
         m_to.delete();
         m_from.delete();
         m_ov = 0;
         m_un = 0;
         return;
      end
      to_push = cpu_write_en && (m_to.size() != D);
      to_pop  = accel_in_ready && (m_to.size() != 0);
      fr_push = accel_out_valid && (m_from.size() != D);
      fr_pop  = cpu_read_en && (m_from.size() != 0);
      if (cpu_write_en && m_to.size() == D) m_ov = 1;
      if (cpu_read_en && m_from.size() == 0) m_un = 1;
      if (to_pop)  void'(m_to.pop_front());
      if (fr_pop)  void'(m_from.pop_front());
      if (to_push) m_to.push_back(cpu_write_data);
      if (fr_push) m_from.push_back(accel_out_data);
   endtask

   task automatic chk_model();
      chk("m_can_write", {31'd0, accel_can_write}, {31'd0, m_to.size() != D});
      chk("m_in_valid",  {31'd0, accel_in_valid},  {31'd0, m_to.size() != 0});
      chk("m_can_read",  {31'd0, accel_can_read},  {31'd0, m_from.size() != 0});
      chk("m_out_ready", {31'd0, accel_out_ready}, {31'd0, m_from.size() != D});
      chk("m_overflow",  {31'd0, overflow},        {31'd0, m_ov});
      chk("m_underflow", {31'd0, underflow},       {31'd0, m_un});
      if (m_to.size() != 0)   chk("m_in_data", accel_in_data, m_to[0]);
      if (m_from.size() != 0) chk("m_rd_data", cpu_read_data, m_from[0]);
   endtask

   // One clock cycle: drive inputs, advance the model, sample #1 after the edge.
   task automatic cyc(input bit r, input bit we, input logic [DW-1:0] wd, input bit re,
                      input bit ir, input bit ovl, input logic [DW-1:0] od);
      rst = r; cpu_write_en = we; cpu_write_data = wd; cpu_read_en = re;
      accel_in_ready = ir; accel_out_valid = ovl; accel_out_data = od;
      model_step();
      @(posedge clk);
      #1;
      chk_model();
   endtask

   typedef struct {
      bit r; bit we; logic [DW-1:0] wd; bit re; bit ir; bit ovl; logic [DW-1:0] od;
      bit cw; bit cr; bit iv; bit ordy; bit ovf; bit unf; logic [DW-1:0] id; logic [DW-1:0] rd;
   } vec_t;

   vec_t tbl[15];

   logic [DW-1:0] words[20];
   logic [DW-1:0] pend[$];

   initial begin
      //             r we wd        re ir ovl od       cw cr iv or ov un id       rd
      tbl[0]  = '{1, 0, 32'h0,    0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 0, 32'h0,  32'h0};
      tbl[1]  = '{0, 0, 32'h0,    0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 0, 32'h0,  32'h0};
      tbl[2]  = '{0, 1, 32'h11,   0, 0, 0, 32'h0,  1, 0, 1, 1, 0, 0, 32'h11, 32'h0};
      tbl[3]  = '{0, 1, 32'h22,   0, 0, 0, 32'h0,  1, 0, 1, 1, 0, 0, 32'h11, 32'h0};
      tbl[4]  = '{0, 1, 32'h33,   0, 0, 0, 32'h0,  1, 0, 1, 1, 0, 0, 32'h11, 32'h0};
      tbl[5]  = '{0, 1, 32'h44,   0, 0, 0, 32'h0,  0, 0, 1, 1, 0, 0, 32'h11, 32'h0};
      tbl[6]  = '{0, 1, 32'h55,   0, 0, 0, 32'h0,  0, 0, 1, 1, 1, 0, 32'h11, 32'h0};
      tbl[7]  = '{0, 0, 32'h0,    0, 1, 0, 32'h0,  1, 0, 1, 1, 1, 0, 32'h22, 32'h0};
      tbl[8]  = '{0, 0, 32'h0,    0, 1, 0, 32'h0,  1, 0, 1, 1, 1, 0, 32'h33, 32'h0};
      tbl[9]  = '{0, 0, 32'h0,    0, 1, 0, 32'h0,  1, 0, 1, 1, 1, 0, 32'h44, 32'h0};
      tbl[10] = '{0, 0, 32'h0,    0, 1, 0, 32'h0,  1, 0, 0, 1, 1, 0, 32'h0,  32'h0};
      tbl[11] = '{0, 0, 32'h0,    0, 0, 1, 32'hA5, 1, 1, 0, 1, 1, 0, 32'h0,  32'hA5};
      tbl[12] = '{0, 0, 32'h0,    1, 0, 0, 32'h0,  1, 0, 0, 1, 1, 0, 32'h0,  32'h0};
      tbl[13] = '{0, 0, 32'h0,    1, 0, 0, 32'h0,  1, 0, 0, 1, 1, 1, 32'h0,  32'h0};
      tbl[14] = '{1, 0, 32'h0,    0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 0, 32'h0,  32'h0};

      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].r, tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].ir, tbl[i].ovl, tbl[i].od);
         chk($sformatf("t%0d_can_write", i), {31'd0, accel_can_write}, {31'd0, tbl[i].cw});
         chk($sformatf("t%0d_can_read", i),  {31'd0, accel_can_read},  {31'd0, tbl[i].cr});
         chk($sformatf("t%0d_in_valid", i),  {31'd0, accel_in_valid},  {31'd0, tbl[i].iv});
         chk($sformatf("t%0d_out_ready", i), {31'd0, accel_out_ready}, {31'd0, tbl[i].ordy});
         chk($sformatf("t%0d_overflow", i),  {31'd0, overflow},        {31'd0, tbl[i].ovf});
         chk($sformatf("t%0d_underflow", i), {31'd0, underflow},       {31'd0, tbl[i].unf});
         if (tbl[i].iv) chk($sformatf("t%0d_in_data", i), accel_in_data, tbl[i].id);
         if (tbl[i].cr) chk($sformatf("t%0d_rd_data", i), cpu_read_data, tbl[i].rd);
      end

      // Full FIFO: simultaneous pop and write; write is rejected, count ends at 3.
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < D; i++) cyc(0, 1, 32'hC1 + i, 0, 0, 0, 0);
      chk("full_can_write", {31'd0, accel_can_write}, 32'd0);
      cyc(0, 1, 32'h99, 0, 1, 0, 0);
      chk("fullpop_overflow", {31'd0, overflow}, 32'd1);
      chk("fullpop_can_write", {31'd0, accel_can_write}, 32'd1);
      chk("fullpop_head", accel_in_data, 32'hC2);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("fullpop_head2", accel_in_data, 32'hC3);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("fullpop_head3", accel_in_data, 32'hC4);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("fullpop_empty", {31'd0, accel_in_valid}, 32'd0);

      // From-accel fill to DEPTH: out_ready drops, and rises the cycle after one pop.
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < D; i++) cyc(0, 0, 0, 0, 0, 1, 32'hE0 + i);
      chk("from_full_ready", {31'd0, accel_out_ready}, 32'd0);
      cyc(0, 0, 0, 1, 0, 1, 32'hEE);
      chk("from_fullpop_ready", {31'd0, accel_out_ready}, 32'd1);
      chk("from_fullpop_head", cpu_read_data, 32'hE1);

      // Underflow is sticky through normal traffic and cleared by reset.
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("underflow_set", {31'd0, underflow}, 32'd1);
      for (int k = 0; k < 10; k++) begin
         cyc(0, 1, k, m_from.size() != 0, 1, 1, k + 100);
         chk("underflow_sticky", {31'd0, underflow}, 32'd1);
      end
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("underflow_clr", {31'd0, underflow}, 32'd0);

      // Reset has priority over simultaneous push activity.
      cyc(0, 1, 32'h1, 0, 0, 1, 32'h2);
      cyc(1, 1, 32'h77, 0, 0, 1, 32'h88);
      chk("rstprio_in_valid", {31'd0, accel_in_valid}, 32'd0);
      chk("rstprio_can_read", {31'd0, accel_can_read}, 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("rstprio_idle", {31'd0, accel_in_valid}, 32'd0);

      // Streaming: accelerator echoes word+1, CPU drains in order.
      begin
         int n_wr = 0;
         int n_rd = 0;
         int t = 0;
         bit we, ir, ovl, re, in_acc, out_acc;
         logic [DW-1:0] in_head;
         for (int i = 0; i < 20; i++) words[i] = $urandom;
         pend.delete();
         cyc(1, 0, 0, 0, 0, 0, 0);
         while (n_rd < 20 && t < 400) begin
            we  = (n_wr < 20) && (m_to.size() < D);
            ir  = 1'($urandom_range(0, 1));
            ovl = pend.size() != 0;
            re  = m_from.size() != 0;
            in_acc  = ir && (m_to.size() != 0);
            in_head = (m_to.size() != 0) ? m_to[0] : '0;
            out_acc = ovl && (m_from.size() != D);
            if (re) chk("stream_data", cpu_read_data, words[n_rd] + 1);
            cyc(0, we, we ? words[n_wr] : '0, re, ir, ovl, ovl ? pend[0] : '0);
            if (out_acc) void'(pend.pop_front());
            if (in_acc)  pend.push_back(in_head + 1);
            if (we) n_wr++;
            if (re) n_rd++;
            t++;
         end
         chk("stream_count", n_rd, 20);
         chk("stream_overflow", {31'd0, overflow}, 32'd0);
         chk("stream_underflow", {31'd0, underflow}, 32'd0);
      end

      // Fully random traffic against the model, with occasional resets.
      for (int t = 0; t < 400; t++) begin
         cyc($urandom_range(0, 39) == 0, 1'($urandom), $urandom, 1'($urandom),
             1'($urandom), 1'($urandom), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cpu_accel_port.md
# cpu_accel_port

Bidirectional buffered port between the CPU core and the function-evaluation accelerator. It produces the `accel_can_read` / `accel_can_write` status inputs consumed by the CPU jump-condition logic (`CR`, `CW`, `NCR`, `NCW`). It carries CPU-written operand words to the accelerator through a to-accel FIFO, and accelerator result words back to the CPU through a from-accel FIFO. Both FIFOs are first-word-fall-through, with valid/ready on the accelerator side and enable strobes on the CPU side.

## Interface
- `DATA_WIDTH`, 32, width of every transferred word
- `DEPTH`, 4, entries per FIFO; power of two, ≥ 2
- `clk` input 1 — single clock; all state updates on rising edge
- `rst` input 1 — synchronous, active-high reset
- `cpu_write_en` input 1 — push `cpu_write_data` into the to-accel FIFO
- `cpu_write_data` input DATA_WIDTH — operand word from the CPU
- `cpu_read_en` input 1 — pop the head of the from-accel FIFO
- `cpu_read_data` output DATA_WIDTH — head of the from-accel FIFO (FWFT)
- `accel_can_write` output 1 — to-accel FIFO not full
- `accel_can_read` output 1 — from-accel FIFO not empty
- `overflow` output 1 — sticky: a CPU write was dropped
- `underflow` output 1 — sticky: a CPU read of an empty FIFO occurred
- `accel_in_valid` output 1 — to-accel FIFO not empty
- `accel_in_data` output DATA_WIDTH — head of the to-accel FIFO
- `accel_in_ready` input 1 — accelerator consumes the head when high together with valid
- `accel_out_valid` input 1 — accelerator offers a result
- `accel_out_data` input DATA_WIDTH — result word
- `accel_out_ready` output 1 — from-accel FIFO not full

## Operation
- Each FIFO has write pointer, read pointer and count.
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
  - Count is `$clog2(DEPTH)+1` bits, range 0..DEPTH.
- All status outputs are decoded combinationally from registered counts only; none depends combinationally on any input.
  - `accel_can_write = (to_count != DEPTH)`
  - `accel_in_valid = (to_count != 0)`
  - `accel_can_read = (from_count != 0)`
  - `accel_out_ready = (from_count != DEPTH)`
- To-accel push: `cpu_write_en && accel_can_write`.
  - `cpu_write_en` while full: the write is dropped, storage is unchanged and `overflow` is set.
- To-accel pop: `accel_in_valid && accel_in_ready`.
- From-accel push: `accel_out_valid && accel_out_ready`.
- From-accel pop: `cpu_read_en && accel_can_read`.
  - `cpu_read_en` while empty: no change and `underflow` is set.
- Full/empty decisions use the count at the start of the cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: both occur and the count is unchanged.
  - On a full FIFO: the pop occurs and the push is rejected, even though a slot frees this cycle.
  - On an empty FIFO: the push occurs and the pop does not.
- `accel_in_data` / `cpu_read_data` = `mem[rd_ptr]` (memory read is combinational). When the FIFO is empty, the value is don't-care.
- `overflow` and `underflow` are sticky. They clear only on `rst`.
- Reset mid-operation: all buffered words are discarded. Memory contents are not cleared.

## Timing
- Reset values, visible the cycle after `rst` is sampled high:
  - `accel_can_write=1`, `accel_out_ready=1`
  - `accel_can_read=0`, `accel_in_valid=0`
  - `overflow=0`, `underflow=0`
  - all pointers and counts = 0
- CPU write in cycle N → `accel_in_valid=1` with that word in cycle N+1.
- Accelerator push in cycle N → `accel_can_read=1` in cycle N+1. A CPU jump on `CR` evaluated in N+1 sees the data.
- Back-to-back throughput is one word per cycle per direction.
- Filling from empty takes DEPTH consecutive writes. `accel_can_write` drops in the cycle after the DEPTH-th write.
- A pop from a full FIFO in cycle N raises `accel_can_write` / `accel_out_ready` in N+1.
- `rst` has priority over all simultaneous push/pop activity in the same cycle.

## Test plan
- Reset, then idle → `accel_can_write=1`, `accel_can_read=0`, `accel_in_valid=0`, `accel_out_ready=1`, `overflow=0`, `underflow=0`.
- CPU writes 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `accel_in_ready=0`, then a 5th write of 0x55:
  - `accel_can_write=0` after the 4th write.
  - 0x55 is dropped and `overflow=1`.
  - Raising `accel_in_ready` yields 0x11, 0x22, 0x33, 0x44 in order, then `accel_in_valid=0`.
- Accelerator pushes 0xA5 in cycle N → `accel_can_read=1` and `cpu_read_data=0xA5` in N+1. `cpu_read_en` in N+1 → `accel_can_read=0` in N+2.
- `cpu_read_en` on an empty from-accel FIFO → `underflow=1`, counts unchanged.
  - `underflow` stays 1 through 10 further cycles of normal traffic and clears on `rst`.
- Full to-accel FIFO, same cycle `cpu_write_en` (0x99) and `accel_in_ready=1` → head is popped, 0x99 is rejected, `overflow=1`, count becomes 3.
- Streaming: 20 words written with `accel_in_ready` toggling pseudo-randomly while the accelerator echoes each word +1 into the from-accel FIFO and the CPU drains it → all 20 results arrive in order with value+1, no flag asserted, pointer wrap exercised five times.
